// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - two-producer round-robin burst arbiter in front of a FIFO write port
//
// Purpose: grants FIFO write access to producer A or B in bursts of up to
// BURST_LEN beats (a single beat while the FIFO is almost full), alternating
// on contention and re-arbitrating at burst end without an idle bubble.
//
// Ports:
//   clk, rst_n                - clock, asynchronous active-low reset
//   a_valid, a_data, a_ready  - producer A beat handshake
//   b_valid, b_data, b_ready  - producer B beat handshake
//   fifo_full                 - FIFO cannot accept a push
//   fifo_almost_full          - FIFO at/above almost-full threshold
//   fifo_push, fifo_wdata     - FIFO write strobe and data
//   grant_id                  - current owner (0 = A, 1 = B), valid while busy
//   busy                      - a grant is active
//   stall_count               - saturating count of stalled cycles
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_valid,
  input  logic [DATA_WIDTH-1:0] a_data,
  output logic                  a_ready,
  input  logic                  b_valid,
  input  logic [DATA_WIDTH-1:0] b_data,
  output logic                  b_ready,
  input  logic                  fifo_full,
  input  logic                  fifo_almost_full,
  output logic                  fifo_push,
  output logic [DATA_WIDTH-1:0] fifo_wdata,
  output logic                  grant_id,
  output logic                  busy,
  output logic [7:0]            stall_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic       last_grant, last_grant_nxt;  // 0 = A, 1 = B
  logic [3:0] beat_cnt, beat_cnt_nxt;

  logic owner_b;
  logic owner_valid;
  logic stall;
  logic burst_end;

  // Round-robin pick: on a tie the producer that did not go last wins.
  function automatic state_t arbitrate(input logic av, input logic bv, input logic lg);
    if (av && bv) return lg ? GRANT_A : GRANT_B;
    else if (av)  return GRANT_A;
    else if (bv)  return GRANT_B;
    else          return IDLE;
  endfunction

  always_comb begin
    owner_b     = (state == GRANT_B);
    owner_valid = owner_b ? b_valid : a_valid;
    busy        = (state != IDLE);
    grant_id    = owner_b;
    a_ready     = (state == GRANT_A) && !fifo_full;
    b_ready     = (state == GRANT_B) && !fifo_full;
    fifo_push   = owner_valid && (a_ready || b_ready);
    fifo_wdata  = owner_b ? b_data : a_data;
    stall       = busy && owner_valid && fifo_full;
    burst_end   = fifo_push && ((beat_cnt == 4'(BURST_LEN - 1)) || fifo_almost_full);
  end

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    beat_cnt_nxt   = beat_cnt;
    case (state)
      IDLE: begin
        state_nxt    = arbitrate(a_valid, b_valid, last_grant);
        beat_cnt_nxt = 4'd0;
      end
      GRANT_A, GRANT_B: begin
        if (!owner_valid) begin
          // Owner went quiet: hand over now, counting the owner as last served.
          state_nxt      = arbitrate(a_valid, b_valid, owner_b);
          last_grant_nxt = owner_b;
          beat_cnt_nxt   = 4'd0;
        end else if (fifo_full) begin
          // Stall: hold everything.
        end else if (burst_end) begin
          // Owner's valid is high here, so it stays eligible if the other is idle.
          state_nxt      = arbitrate(owner_b ? a_valid : 1'b1,
                                     owner_b ? 1'b1 : b_valid,
                                     owner_b);
          last_grant_nxt = owner_b;
          beat_cnt_nxt   = 4'd0;
        end else begin
          beat_cnt_nxt = beat_cnt + 4'd1;
        end
      end
      default: begin
        state_nxt    = IDLE;
        beat_cnt_nxt = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_grant  <= 1'b1;  // B counts as last so A wins the first tie
      beat_cnt    <= 4'd0;
      stall_count <= 8'd0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      beat_cnt   <= beat_cnt_nxt;
      if (stall && (stall_count != 8'hFF)) begin
        stall_count <= stall_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          a_valid = 1'b0;
  logic [DW-1:0] a_data = '0;
  logic          a_ready;
  logic          b_valid = 1'b0;
  logic [DW-1:0] b_data = '0;
  logic          b_ready;
  logic          fifo_full = 1'b0;
  logic          fifo_almost_full = 1'b0;
  logic          fifo_push;
  logic [DW-1:0] fifo_wdata;
  logic          grant_id;
  logic          busy;
  logic [7:0]    stall_count;

  int total_cnt = 0;
  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int step_idx  = 0;

  fifo_wr_arbiter #(.DATA_WIDTH(DW), .BURST_LEN(4)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .a_valid          (a_valid),
    .a_data           (a_data),
    .a_ready          (a_ready),
    .b_valid          (b_valid),
    .b_data           (b_data),
    .b_ready          (b_ready),
    .fifo_full        (fifo_full),
    .fifo_almost_full (fifo_almost_full),
    .fifo_push        (fifo_push),
    .fifo_wdata       (fifo_wdata),
    .grant_id         (grant_id),
    .busy             (busy),
    .stall_count      (stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, then check the
  // combinational outputs before the next rising edge.
  task automatic step(input string tag, input logic av, input logic bv,
                      input logic full, input logic af,
                      input logic e_busy, input logic e_gid, input logic e_push);
    @(negedge clk);
    step_idx++;
    a_valid          = av;
    b_valid          = bv;
    fifo_full        = full;
    fifo_almost_full = af;
    a_data           = 8'hA0 + 8'(step_idx);
    b_data           = 8'h50 + 8'(step_idx);
    #1;
    chk({tag, "_busy"}, 32'(busy), 32'(e_busy));
    chk({tag, "_push"}, 32'(fifo_push), 32'(e_push));
    chk({tag, "_a_ready"}, 32'(a_ready), 32'(e_busy && !e_gid && !full));
    chk({tag, "_b_ready"}, 32'(b_ready), 32'(e_busy && e_gid && !full));
    if (e_busy) chk({tag, "_grant_id"}, 32'(grant_id), 32'(e_gid));
    chk({tag, "_wdata"}, 32'(fifo_wdata), 32'((e_busy && e_gid) ? b_data : a_data));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_a_ready"}, 32'(a_ready), 32'd0);
    chk({tag, "_b_ready"}, 32'(b_ready), 32'd0);
    chk({tag, "_push"}, 32'(fifo_push), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_grant_id"}, 32'(grant_id), 32'd0);
    chk({tag, "_wdata"}, 32'(fifo_wdata), 32'(a_data));
    chk({tag, "_stall_count"}, 32'(stall_count), 32'd0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    a_data = 8'h3C;
    b_data = 8'hC3;
    #1;
    check_reset_outputs(tag);
    @(negedge clk);
    rst_n            = 1'b1;
    a_valid          = 1'b0;
    b_valid          = 1'b0;
    fifo_full        = 1'b0;
    fifo_almost_full = 1'b0;
  endtask

  initial begin
    // Both producers always valid: A x4, B x4, A x4, no bubbles.
    do_reset("s1_rst");
    step("s1_idle", 1, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) step("s1_beat", 1, 1, 0, 0, 1, 1'((i / 4) % 2), 1);

    // Only B: 10 back-to-back beats, then release to IDLE.
    do_reset("s2_rst");
    step("s2_idle", 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step("s2_beat", 0, 1, 0, 0, 1, 1, 1);
    step("s2_release", 0, 0, 0, 0, 1, 1, 0);
    step("s2_idle_end", 0, 0, 0, 0, 0, 0, 0);

    // Full for 3 cycles mid-burst of A; burst resumes with 2 remaining beats.
    do_reset("s3_rst");
    step("s3_idle", 1, 0, 0, 0, 0, 0, 0);
    step("s3_beat1", 1, 0, 0, 0, 1, 0, 1);
    step("s3_beat2", 1, 0, 0, 0, 1, 0, 1);
    for (int i = 0; i < 3; i++) step("s3_stall", 1, 0, 1, 0, 1, 0, 0);
    step("s3_beat3", 1, 1, 0, 0, 1, 0, 1);
    chk("s3_stall_count", 32'(stall_count), 32'd3);
    step("s3_beat4", 1, 1, 0, 0, 1, 0, 1);
    step("s3_b_after", 1, 1, 0, 0, 1, 1, 1);

    // Almost full: single-beat alternation A,B,A,B.
    do_reset("s4_rst");
    step("s4_idle", 1, 1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step("s4_beat", 1, 1, 0, 1, 1, 1'(i % 2), 1);

    // A drops after 2 beats -> B immediately; later tie after B burst -> A.
    do_reset("s5_rst");
    step("s5_idle", 1, 1, 0, 0, 0, 0, 0);
    step("s5_a1", 1, 1, 0, 0, 1, 0, 1);
    step("s5_a2", 1, 1, 0, 0, 1, 0, 1);
    step("s5_a_drop", 0, 1, 0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) step("s5_b", 1, 1, 0, 0, 1, 1, 1);
    step("s5_tie_a", 1, 1, 0, 0, 1, 0, 1);

    // Reset mid-burst, A wins first after reset, stall counter saturates.
    do_reset("s6_rst");
    step("s6_idle", 1, 1, 0, 0, 0, 0, 0);
    step("s6_a1", 1, 1, 0, 0, 1, 0, 1);
    step("s6_a2", 1, 1, 0, 0, 1, 0, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("s6_midrst");
    @(negedge clk);
    #1;
    check_reset_outputs("s6_midrst_hold");
    rst_n = 1'b1;
    #1;
    chk("s6_post_rst_busy", 32'(busy), 32'd0);
    chk("s6_post_rst_push", 32'(fifo_push), 32'd0);
    step("s6_first_a", 1, 1, 0, 0, 1, 0, 1);
    for (int i = 0; i < 260; i++) begin
      step("s6_stall", 1, 1, 1, 0, 1, 0, 0);
      if (i == 100) chk("s6_stall_count_100", 32'(stall_count), 32'd100);
    end
    step("s6_resume", 1, 1, 0, 0, 1, 0, 1);
    chk("s6_stall_count_sat", 32'(stall_count), 32'd255);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of the producer and FIFO data buses.
REQ-002 SHALL have parameter BURST_LEN, default 4, maximum beats per grant (legal range 1..15).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous and active-low.
REQ-005 SHALL have port a_valid  input  1  producer A has a beat on a_data.
REQ-006 SHALL have port a_data  input  DATA_WIDTH  producer A beat.
REQ-007 SHALL have port a_ready  output  1  producer A beat accepted this cycle when a_valid is also high.
REQ-008 SHALL have port b_valid  input  1  producer B has a beat on b_data.
REQ-009 SHALL have port b_data  input  DATA_WIDTH  producer B beat.
REQ-010 SHALL have port b_ready  output  1  producer B beat accepted this cycle when b_valid is also high.
REQ-011 SHALL have port fifo_full  input  1  FIFO cannot accept a push.
REQ-012 SHALL have port fifo_almost_full  input  1  FIFO occupancy at or above its almost-full threshold.
REQ-013 SHALL have port fifo_push  output  1  write strobe to the FIFO.
REQ-014 SHALL have port fifo_wdata  output  DATA_WIDTH  data to the FIFO.
REQ-015 SHALL have port grant_id  output  1  current owner: 0 = A, 1 = B; valid only while busy.
REQ-016 SHALL have port busy  output  1  high in GRANT_A or GRANT_B.
REQ-017 SHALL have port stall_count  output  8  saturating count of stalled cycles.

Function
REQ-018 SHALL implement states IDLE, GRANT_A, GRANT_B in a registered state variable.
REQ-019 SHALL drive a_ready = (state==GRANT_A) and not fifo_full; b_ready likewise for GRANT_B.
REQ-020 SHALL drive fifo_push = owner valid and owner ready; fifo_wdata = owner data (A data when not busy).
REQ-021 SHALL never assert fifo_push while fifo_full is high, and never assert a_ready and b_ready together.
REQ-022 SHALL arbitrate round-robin via register last_grant: both valid -> grant the producer not in last_grant; one valid -> grant it; none -> IDLE.
REQ-023 SHALL move IDLE -> GRANT_x one cycle after arbitration; no beat is accepted in IDLE.
REQ-024 SHALL count accepted beats in a 4-bit beat counter, cleared on every new grant.
REQ-025 SHALL limit a burst to BURST_LEN beats, or 1 beat if fifo_almost_full is high in the cycle of the beat.
REQ-026 SHALL, at a beat that ends the burst, re-arbitrate in that cycle (owner's valid counts as held) and go directly to the next GRANT state with no idle bubble, updating last_grant to the finishing owner.
REQ-027 SHALL, when the owner's valid is low while granted, release the grant: arbitrate immediately, treating the owner as last_grant.
REQ-028 SHALL hold state and beat counter while fifo_full is high and the owner's valid is high (stall).
REQ-029 SHALL increment stall_count on each stall cycle, saturating at 255.
REQ-030 SHALL present beats to the FIFO in acceptance order; no beat is duplicated or lost.

Reset
REQ-031 SHALL on rst_n low immediately set state IDLE, beat counter 0, last_grant = B (A wins first tie), stall_count 0.
REQ-032 SHALL force a_ready, b_ready, fifo_push, busy, grant_id to 0 while in reset; fifo_wdata = a_data.
REQ-033 SHALL abandon any burst in progress on reset mid-operation; no beat is accepted until re-arbitration.

Verification
REQ-034 SHALL cover: reset, then a_valid=b_valid=1 continuously, FIFO never full -> grants A x4, B x4, A x4 alternately, no bubbles after the first.
REQ-035 SHALL cover: only b_valid high for 10 beats -> back-to-back B bursts of 4,4,2, grant_id=1 throughout.
REQ-036 SHALL cover: fifo_full high for 3 cycles mid-burst of A -> a_ready=0, fifo_push=0, stall_count +3, burst resumes with remaining beats.
REQ-037 SHALL cover: fifo_almost_full high with both valid -> single-beat alternation A,B,A,B.
REQ-038 SHALL cover: a_valid drops after 2 beats while b_valid is high -> GRANT_B in the same cycle; later b_valid=1 and a_valid=1 tie -> A granted.
REQ-039 SHALL cover: rst_n asserted mid-burst, then 260 stall cycles -> outputs 0 during reset, A granted first after reset, stall_count saturates at 255.
